ctrl_issue_stage: RTL and testbench

Registered decode-and-issue stage between the ID and EXE stages of the ARM pipeline. It decodes mode/opcode/S into execute and memory controls, evaluates the 4-bit ARM condition field against the current NZCV flags, and holds the result in a valid/ready output register. It also inserts load-use and flag-dependency bubbles and squashes a parametrised branch shadow.

---
 rtl/ctrl_issue_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_ctrl_issue_stage.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_issue_stage.sv
// ---------------------------------------------------------------------------
// ctrl_issue_stage
//
// Registered decode-and-issue stage sitting between ID and EXE of the ARM
// pipeline. The incoming instruction (mode/opcode/S) is decoded into execute
// and memory controls. The 4-bit ARM condition field is evaluated against the
// committed NZCV flags, and the result is held in a valid/ready output
// register. The stage also inserts load-use and flag-dependency bubbles and
// squashes a configurable number of instructions after a taken branch.
//
// Parameters
//   CMD_W         exe command width (>= 4); the 4-bit command is zero-extended
//   REG_W         register-address width
//   BRANCH_SHADOW instructions squashed after a taken branch (0..3)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready is combinational)
//   mode, opcode, s_bit      instruction class, ALU opcode, S / load-store bit
//   cond, status             condition code and committed {N,Z,C,V}
//   rn, rd, rm, src2_is_reg  register operands and rm-is-read flag
//   flush                    synchronous pipeline flush
//   out_valid / out_ready    downstream handshake
//   out_exe_cmd ... out_undef registered decoded entry
// ---------------------------------------------------------------------------
module ctrl_issue_stage #(
    parameter int CMD_W         = 4,
    parameter int REG_W         = 4,
    parameter int BRANCH_SHADOW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [3:0]       opcode,
    input  logic             s_bit,
    input  logic [3:0]       cond,
    input  logic [3:0]       status,
    input  logic [REG_W-1:0] rn,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rm,
    input  logic             src2_is_reg,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CMD_W-1:0] out_exe_cmd,
    output logic             out_s_update,
    output logic             out_branch,
    output logic             out_mem_w,
    output logic             out_mem_r,
    output logic             out_wb_en,
    output logic [REG_W-1:0] out_dest,
    output logic             out_undef
);

    // Instruction classes
    localparam logic [1:0] MODE_ALU    = 2'b00;
    localparam logic [1:0] MODE_MEM    = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;

    // ALU opcodes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] SHADOW_LOAD = 2'(BRANCH_SHADOW);

    // Decoded (pre-condition, pre-squash) controls
    logic [3:0]  cmd_s;
    logic        s_update_s;
    logic        branch_s;
    logic        mem_w_s;
    logic        mem_r_s;
    logic        wb_s;
    logic        undef_s;

    logic        cond_pass_s;
    logic        rn_read_s;
    logic        rm_read_s;
    logic        rd_read_s;
    logic        load_use_s;
    logic        flag_hazard_s;
    logic        stall_s;
    logic        accept_s;
    logic        squash_s;
    logic        enable_s;

    logic [1:0]  shadow_cnt_r;

    // Decode mode/opcode/S into raw execute and memory controls
    always_comb begin
        cmd_s      = 4'd0;
        s_update_s = 1'b0;
        branch_s   = 1'b0;
        mem_w_s    = 1'b0;
        mem_r_s    = 1'b0;
        wb_s       = 1'b0;
        undef_s    = 1'b0;
        case (mode)
            MODE_ALU: begin
                case (opcode)
                    OP_MOV:  begin cmd_s = 4'd1; s_update_s = s_bit; wb_s = 1'b1; end
                    OP_MVN:  begin cmd_s = 4'd9; s_update_s = s_bit; wb_s = 1'b1; end
                    OP_ADD:  begin cmd_s = 4'd2; s_update_s = s_bit; wb_s = 1'b1; end
                    OP_ADC:  begin cmd_s = 4'd3; s_update_s = s_bit; wb_s = 1'b1; end
                    OP_SUB:  begin cmd_s = 4'd4; s_update_s = s_bit; wb_s = 1'b1; end
                    OP_SBC:  begin cmd_s = 4'd5; s_update_s = s_bit; wb_s = 1'b1; end
                    OP_AND:  begin cmd_s = 4'd6; s_update_s = s_bit; wb_s = 1'b1; end
                    OP_ORR:  begin cmd_s = 4'd7; s_update_s = s_bit; wb_s = 1'b1; end
                    OP_EOR:  begin cmd_s = 4'd8; s_update_s = s_bit; wb_s = 1'b1; end
                    // Compare/test only update flags, never write back
                    OP_CMP:  begin cmd_s = 4'd4; s_update_s = 1'b1; end
                    OP_TST:  begin cmd_s = 4'd6; s_update_s = 1'b1; end
                    default: begin cmd_s = 4'd0; end
                endcase
            end
            MODE_MEM: begin
                cmd_s = 4'd2;
                if (s_bit) begin
                    mem_r_s = 1'b1;
                    wb_s    = 1'b1;
                end else begin
                    mem_w_s = 1'b1;
                end
            end
            MODE_BRANCH: begin
                branch_s = 1'b1;
            end
            default: begin
                undef_s = 1'b1;
            end
        endcase
    end

    // Evaluate the ARM condition field against committed {N,Z,C,V}
    always_comb begin
        cond_pass_s = 1'b0;
        case (cond)
            4'b0000: cond_pass_s = status[2];                                   // EQ
            4'b0001: cond_pass_s = !status[2];                                  // NE
            4'b0010: cond_pass_s = status[1];                                   // CS
            4'b0011: cond_pass_s = !status[1];                                  // CC
            4'b0100: cond_pass_s = status[3];                                   // MI
            4'b0101: cond_pass_s = !status[3];                                  // PL
            4'b0110: cond_pass_s = status[0];                                   // VS
            4'b0111: cond_pass_s = !status[0];                                  // VC
            4'b1000: cond_pass_s = status[1] && !status[2];                     // HI
            4'b1001: cond_pass_s = !status[1] || status[2];                     // LS
            4'b1010: cond_pass_s = (status[3] == status[0]);                    // GE
            4'b1011: cond_pass_s = (status[3] != status[0]);                    // LT
            4'b1100: cond_pass_s = !status[2] && (status[3] == status[0]);      // GT
            4'b1101: cond_pass_s = status[2] || (status[3] != status[0]);       // LE
            4'b1110: cond_pass_s = 1'b1;                                        // AL
            default: cond_pass_s = 1'b0;                                        // never
        endcase
    end

    // Determine which register fields the incoming instruction reads
    always_comb begin
        rn_read_s = 1'b0;
        rm_read_s = 1'b0;
        rd_read_s = 1'b0;
        if (mode == MODE_BRANCH) begin
            rn_read_s = 1'b0;
        end else if ((mode == MODE_ALU) && ((opcode == OP_MOV) || (opcode == OP_MVN))) begin
            rn_read_s = 1'b0;
        end else begin
            rn_read_s = 1'b1;
        end
        if ((mode == MODE_ALU) || (mode == MODE_MEM)) begin
            rm_read_s = src2_is_reg;
        end else begin
            rm_read_s = 1'b0;
        end
        // A store reads rd as its data operand
        if ((mode == MODE_MEM) && !s_bit) begin
            rd_read_s = 1'b1;
        end else begin
            rd_read_s = 1'b0;
        end
    end

    // A load still sitting in the output register cannot forward its result
    assign load_use_s = out_valid && out_mem_r && in_valid &&
                        ((rn_read_s && (rn == out_dest)) ||
                         (rm_read_s && (rm == out_dest)) ||
                         (rd_read_s && (rd == out_dest)));

    // Flags from the entry ahead are not yet committed to status
    assign flag_hazard_s = out_valid && out_s_update && (cond != COND_AL);

    assign stall_s  = load_use_s || flag_hazard_s;
    assign in_ready = !flush && !stall_s && (!out_valid || out_ready);
    assign accept_s = in_valid && in_ready;

    // Inside a branch shadow every accepted instruction is killed
    assign squash_s = (shadow_cnt_r != 2'd0);
    assign enable_s = cond_pass_s && !squash_s;

    // Output register and branch-shadow counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_exe_cmd  <= {CMD_W{1'b0}};
            out_s_update <= 1'b0;
            out_branch   <= 1'b0;
            out_mem_w    <= 1'b0;
            out_mem_r    <= 1'b0;
            out_wb_en    <= 1'b0;
            out_dest     <= {REG_W{1'b0}};
            out_undef    <= 1'b0;
            shadow_cnt_r <= 2'd0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            shadow_cnt_r <= 2'd0;
        end else if (accept_s) begin
            out_valid    <= 1'b1;
            out_exe_cmd  <= CMD_W'(cmd_s);
            out_s_update <= s_update_s && enable_s;
            out_branch   <= branch_s && enable_s;
            out_mem_w    <= mem_w_s && enable_s;
            out_mem_r    <= mem_r_s && enable_s;
            out_wb_en    <= wb_s && enable_s;
            out_dest     <= rd;
            out_undef    <= undef_s && !squash_s;
            // A branch inside a shadow is itself squashed and never reloads
            if (squash_s) begin
                shadow_cnt_r <= shadow_cnt_r - 2'd1;
            end else if (branch_s && cond_pass_s) begin
                shadow_cnt_r <= SHADOW_LOAD;
            end else begin
                shadow_cnt_r <= 2'd0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_ctrl_issue_stage
//
// Directed self-checking bench for ctrl_issue_stage with BRANCH_SHADOW=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_ctrl_issue_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] mode;
    logic [3:0] opcode;
    logic       s_bit;
    logic [3:0] cond;
    logic [3:0] status;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;
    logic       src2_is_reg;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_exe_cmd;
    logic       out_s_update;
    logic       out_branch;
    logic       out_mem_w;
    logic       out_mem_r;
    logic       out_wb_en;
    logic [3:0] out_dest;
    logic       out_undef;

    int tests = 0;
    int fails = 0;

    localparam logic [3:0] AL = 4'b1110;

    ctrl_issue_stage #(.CMD_W(4), .REG_W(4), .BRANCH_SHADOW(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .opcode(opcode), .s_bit(s_bit), .cond(cond),
        .status(status), .rn(rn), .rd(rd), .rm(rm),
        .src2_is_reg(src2_is_reg), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_exe_cmd(out_exe_cmd),
        .out_s_update(out_s_update), .out_branch(out_branch),
        .out_mem_w(out_mem_w), .out_mem_r(out_mem_r), .out_wb_en(out_wb_en),
        .out_dest(out_dest), .out_undef(out_undef)
    );

    always #5 clk = ~clk;

    // {valid, cmd, s_update, branch, mem_w, mem_r, wb, undef}
    wire [10:0] obs = {out_valid, out_exe_cmd, out_s_update, out_branch,
                       out_mem_w, out_mem_r, out_wb_en, out_undef};
    wire [4:0]  en  = {out_s_update, out_branch, out_mem_w, out_mem_r, out_wb_en};

    // Expected ALU decode: {cmd, s_update, wb}
    function automatic logic [5:0] exp_alu(input logic [3:0] op, input logic s);
        case (op)
            4'b1101: exp_alu = {4'd1, s, 1'b1};
            4'b1111: exp_alu = {4'd9, s, 1'b1};
            4'b0100: exp_alu = {4'd2, s, 1'b1};
            4'b0101: exp_alu = {4'd3, s, 1'b1};
            4'b0010: exp_alu = {4'd4, s, 1'b1};
            4'b0110: exp_alu = {4'd5, s, 1'b1};
            4'b0000: exp_alu = {4'd6, s, 1'b1};
            4'b1100: exp_alu = {4'd7, s, 1'b1};
            4'b0001: exp_alu = {4'd8, s, 1'b1};
            4'b1010: exp_alu = {4'd4, 1'b1, 1'b0};
            4'b1000: exp_alu = {4'd6, 1'b1, 1'b0};
            default: exp_alu = 6'd0;
        endcase
    endfunction

    // ARM condition truth table, flags f = {N,Z,C,V}
    function automatic logic cpass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'd0:    cpass = z;
            4'd1:    cpass = ~z;
            4'd2:    cpass = cf;
            4'd3:    cpass = ~cf;
            4'd4:    cpass = n;
            4'd5:    cpass = ~n;
            4'd6:    cpass = v;
            4'd7:    cpass = ~v;
            4'd8:    cpass = cf & ~z;
            4'd9:    cpass = ~cf | z;
            4'd10:   cpass = ~(n ^ v);
            4'd11:   cpass = n ^ v;
            4'd12:   cpass = ~z & ~(n ^ v);
            4'd13:   cpass = z | (n ^ v);
            4'd14:   cpass = 1'b1;
            default: cpass = 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] m, input logic [3:0] op, input logic s,
                          input logic [3:0] c, input logic [3:0] a, input logic [3:0] d,
                          input logic [3:0] b, input logic r2);
        in_valid = 1'b1; mode = m; opcode = op; s_bit = s; cond = c;
        rn = a; rd = d; rm = b; src2_is_reg = r2;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        mode = 2'b00; opcode = 4'd0; s_bit = 1'b0; cond = AL; status = 4'd0;
        rn = 4'd0; rd = 4'd0; rm = 4'd0; src2_is_reg = 1'b0;
        step();
        step();
        tests++;
        if (obs !== 11'd0 || out_dest !== 4'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%b dest=%0d exp=0", obs, out_dest);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        rst = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_decode();
        logic [5:0]  e;
        logic [10:0] x;
        for (int op = 0; op < 16; op++) begin
            for (int s = 0; s < 2; s++) begin
                set_in(2'b00, 4'(op), 1'(s), AL, 4'd1, 4'd2, 4'd3, 1'b0);
                step();
                e = exp_alu(4'(op), 1'(s));
                x = {1'b1, e[5:2], e[1], 1'b0, 1'b0, 1'b0, e[0], 1'b0};
                tests++;
                if (obs !== x) begin
                    fails++;
                    $display("FAIL decode_alu op=%0d s=%0d got=%b exp=%b", op, s, obs, x);
                end
            end
        end
        set_in(2'b01, 4'd0, 1'b0, AL, 4'd1, 4'd2, 4'd3, 1'b0);   // store
        step();
        tests++;
        if (obs !== {1'b1, 4'd2, 6'b001000}) begin
            fails++;
            $display("FAIL decode_store got=%b exp=%b", obs, {1'b1, 4'd2, 6'b001000});
        end
        set_in(2'b01, 4'd0, 1'b1, AL, 4'd1, 4'd2, 4'd3, 1'b0);   // load
        step();
        tests++;
        if (obs !== {1'b1, 4'd2, 6'b000110} || out_dest !== 4'd2) begin
            fails++;
            $display("FAIL decode_load got=%b dest=%0d exp=%b dest=2", obs, out_dest, {1'b1, 4'd2, 6'b000110});
        end
        set_in(2'b11, 4'd4, 1'b1, AL, 4'd1, 4'd2, 4'd3, 1'b0);   // undefined
        step();
        tests++;
        if (obs !== {1'b1, 4'd0, 6'b000001}) begin
            fails++;
            $display("FAIL decode_undef got=%b exp=%b", obs, {1'b1, 4'd0, 6'b000001});
        end
        set_in(2'b10, 4'd0, 1'b0, AL, 4'd1, 4'd2, 4'd3, 1'b0);   // branch
        step();
        tests++;
        if (obs !== {1'b1, 4'd0, 6'b010000}) begin
            fails++;
            $display("FAIL decode_branch got=%b exp=%b", obs, {1'b1, 4'd0, 6'b010000});
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
    endtask

    task automatic test_conditions();
        logic p;
        drain();
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                status = 4'(f);
                set_in(2'b00, 4'b0100, 1'b0, 4'(c), 4'd1, 4'd2, 4'd3, 1'b0);
                step();
                p = cpass(4'(c), 4'(f));
                tests++;
                if ({out_valid, out_wb_en} !== {1'b1, p}) begin
                    fails++;
                    $display("FAIL cond c=%0d nzcv=%b got v=%b wb=%b exp v=1 wb=%b",
                             c, f[3:0], out_valid, out_wb_en, p);
                end
            end
        end
        // GT with Z=0, N=V=1 passes; with N!=V it fails
        status = 4'b1001;
        set_in(2'b00, 4'b0100, 1'b0, 4'b1100, 4'd1, 4'd2, 4'd3, 1'b0);
        step();
        tests++;
        if (out_wb_en !== 1'b1) begin
            fails++;
            $display("FAIL cond_gt_pass got=%b exp=1", out_wb_en);
        end
        status = 4'b1000;
        step();
        tests++;
        if (out_wb_en !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL cond_gt_fail got wb=%b v=%b exp wb=0 v=1", out_wb_en, out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_load_use();
        drain();
        status = 4'd0;
        set_in(2'b01, 4'd0, 1'b1, AL, 4'd5, 4'd3, 4'd0, 1'b0);   // LDR r3
        step();
        set_in(2'b00, 4'b0100, 1'b0, AL, 4'd3, 4'd1, 4'd2, 1'b1); // ADD r1,r3,r2
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL load_use_stall in_ready got=%b exp=0", in_ready);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL load_use_bubble got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_dest !== 4'd1 || out_wb_en !== 1'b1) begin
            fails++;
            $display("FAIL load_use_issue got v=%b dest=%0d wb=%b exp v=1 dest=1 wb=1",
                     out_valid, out_dest, out_wb_en);
        end
        set_in(2'b01, 4'd0, 1'b1, AL, 4'd5, 4'd3, 4'd0, 1'b0);   // LDR r3
        step();
        set_in(2'b00, 4'b0100, 1'b0, AL, 4'd4, 4'd1, 4'd2, 1'b1); // ADD r1,r4,r2
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL load_nouse_ready got=%b exp=1", in_ready);
        end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_dest !== 4'd1 || out_mem_r !== 1'b0) begin
            fails++;
            $display("FAIL load_nouse_issue got v=%b dest=%0d mr=%b exp v=1 dest=1 mr=0",
                     out_valid, out_dest, out_mem_r);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flag_dep();
        drain();
        status = 4'b0100;                                          // Z=1
        set_in(2'b00, 4'b0010, 1'b1, AL, 4'd1, 4'd4, 4'd2, 1'b0); // SUBS
        step();
        set_in(2'b00, 4'b0100, 1'b0, 4'b0000, 4'd1, 4'd5, 4'd2, 1'b0); // ADDEQ
        #1;
        tests++;
        if (in_ready !== 1'b0 || out_s_update !== 1'b1) begin
            fails++;
            $display("FAIL flag_stall got rdy=%b s=%b exp rdy=0 s=1", in_ready, out_s_update);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flag_bubble got=%b exp=0", out_valid);
        end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_wb_en !== 1'b1 || out_dest !== 4'd5) begin
            fails++;
            $display("FAIL flag_issue got v=%b wb=%b dest=%0d exp v=1 wb=1 dest=5",
                     out_valid, out_wb_en, out_dest);
        end
        set_in(2'b00, 4'b0010, 1'b1, AL, 4'd1, 4'd4, 4'd2, 1'b0); // SUBS
        step();
        set_in(2'b00, 4'b0100, 1'b0, AL, 4'd1, 4'd6, 4'd2, 1'b0); // ADD (AL)
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flag_al_ready got=%b exp=1", in_ready);
        end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_dest !== 4'd6 || out_wb_en !== 1'b1) begin
            fails++;
            $display("FAIL flag_al_issue got v=%b dest=%0d wb=%b exp v=1 dest=6 wb=1",
                     out_valid, out_dest, out_wb_en);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_branch_shadow();
        drain();
        status = 4'd0;
        set_in(2'b10, 4'd0, 1'b0, AL, 4'd0, 4'd0, 4'd0, 1'b0);   // B taken
        step();
        tests++;
        if (out_branch !== 1'b1) begin
            fails++;
            $display("FAIL shadow_branch got=%b exp=1", out_branch);
        end
        for (int i = 0; i < 3; i++) begin
            set_in(2'b00, 4'b0100, 1'b0, AL, 4'd1, 4'(i + 1), 4'd2, 1'b0);
            step();
            tests++;
            if (i < 2) begin
                if (out_valid !== 1'b1 || en !== 5'b00000 || out_undef !== 1'b0) begin
                    fails++;
                    $display("FAIL shadow_squash idx=%0d got v=%b en=%b u=%b exp v=1 en=00000 u=0",
                             i, out_valid, en, out_undef);
                end
            end else begin
                if (out_valid !== 1'b1 || en !== 5'b00001) begin
                    fails++;
                    $display("FAIL shadow_release got v=%b en=%b exp v=1 en=00001", out_valid, en);
                end
            end
        end
        // Branch inside the shadow is squashed and must not reload the counter
        set_in(2'b10, 4'd0, 1'b0, AL, 4'd0, 4'd0, 4'd0, 1'b0);
        step();
        step();
        tests++;
        if (out_branch !== 1'b0) begin
            fails++;
            $display("FAIL shadow_inner_branch got=%b exp=0", out_branch);
        end
        set_in(2'b00, 4'b0100, 1'b0, AL, 4'd1, 4'd7, 4'd2, 1'b0);
        step();
        tests++;
        if (en !== 5'b00000) begin
            fails++;
            $display("FAIL shadow_inner_squash got=%b exp=00000", en);
        end
        step();
        tests++;
        if (en !== 5'b00001) begin
            fails++;
            $display("FAIL shadow_no_reload got=%b exp=00001", en);
        end
        // Not-taken branch (EQ with Z=0) squashes nothing
        set_in(2'b10, 4'd0, 1'b0, 4'b0000, 4'd0, 4'd0, 4'd0, 1'b0);
        step();
        tests++;
        if (out_valid !== 1'b1 || out_branch !== 1'b0) begin
            fails++;
            $display("FAIL shadow_not_taken got v=%b br=%b exp v=1 br=0", out_valid, out_branch);
        end
        set_in(2'b00, 4'b0100, 1'b0, AL, 4'd1, 4'd8, 4'd2, 1'b0);
        step();
        tests++;
        if (en !== 5'b00001) begin
            fails++;
            $display("FAIL shadow_not_taken_next got=%b exp=00001", en);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        drain();
        set_in(2'b00, 4'b0100, 1'b0, AL, 4'd1, 4'd7, 4'd2, 1'b0);
        step();
        out_ready = 1'b0;
        set_in(2'b00, 4'b0100, 1'b0, AL, 4'd1, 4'd8, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (obs !== {1'b1, 4'd2, 6'b000010} || out_dest !== 4'd7 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold cyc=%0d got=%b dest=%0d rdy=%b exp=%b dest=7 rdy=0",
                         i, obs, out_dest, in_ready, {1'b1, 4'd2, 6'b000010});
            end
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_release got=%b exp=1", in_ready);
        end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_dest !== 4'd8) begin
            fails++;
            $display("FAIL backpressure_next got v=%b dest=%0d exp v=1 dest=8", out_valid, out_dest);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        drain();
        set_in(2'b00, 4'b0100, 1'b0, AL, 4'd1, 4'd9, 4'd2, 1'b0);
        step();
        set_in(2'b00, 4'b0100, 1'b0, AL, 4'd1, 4'd10, 4'd2, 1'b0);
        flush = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_ready got=%b exp=0", in_ready);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_valid got=%b exp=0", out_valid);
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_not_taken got=%b exp=0", out_valid);
        end
        // Flush also clears a pending branch shadow
        set_in(2'b10, 4'd0, 1'b0, AL, 4'd0, 4'd0, 4'd0, 1'b0);
        step();
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        set_in(2'b00, 4'b0100, 1'b0, AL, 4'd1, 4'd11, 4'd2, 1'b0);
        step();
        tests++;
        if (out_valid !== 1'b1 || en !== 5'b00001) begin
            fails++;
            $display("FAIL flush_clears_shadow got v=%b en=%b exp v=1 en=00001", out_valid, en);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        drain();
        set_in(2'b00, 4'b0100, 1'b1, AL, 4'd1, 4'd12, 4'd2, 1'b0);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b1 || out_dest !== 4'd12) begin
            fails++;
            $display("FAIL async_pre_hold got v=%b dest=%0d exp v=1 dest=12", out_valid, out_dest);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (obs !== 11'd0 || out_dest !== 4'd0) begin
            fails++;
            $display("FAIL async_reset got=%b dest=%0d exp=0", obs, out_dest);
        end
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_after got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_conditions();
        test_load_use();
        test_flag_dep();
        test_branch_shadow();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
